// File: rtl/hack_cpu_seq.sv
// hack_cpu_seq: multi-cycle Hack CPU sequencer.
// Fetches over a req/ack instruction port, decodes, drives the external ALU,
// and owns the A, D and PC registers plus data-memory read/write transactions.
// Optional feature macro: HACK_HALT_SELFJUMP_EN. When it is defined, a taken
// self-jump parks the block in HALT and sets halted=1.
module hack_cpu_seq #(
  parameter int PC_WIDTH = 15,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction port
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic                instr_ack,
  input  logic [15:0]         instr_rdata,
  // data port
  output logic                mem_req,
  output logic                mem_we,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [15:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [15:0]         mem_rdata,
  // ALU control side
  output logic [15:0]         alu_x,
  output logic [15:0]         alu_y,
  output logic                alu_zx,
  output logic                alu_nx,
  output logic                alu_zy,
  output logic                alu_ny,
  output logic                alu_f,
  output logic                alu_no,
  input  logic [15:0]         alu_out,
  input  logic                alu_zr,
  input  logic                alu_ng,
  // debug
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [15:0]         a_o,
  output logic [15:0]         d_o,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_MREAD, S_EXEC, S_MWRITE, S_HALT
  } state_t;

  state_t              state, nxt;
  logic [PC_WIDTH-1:0] pc, waddr;
  logic [15:0]         a, d, ir, m_lat, res;
  logic                jmp_taken;
  logic [PC_WIDTH-1:0] jmp_tgt, pc_inc;
  logic                self_jmp;

  // Jump condition and target come from the pre-update A and the live flags.
  assign jmp_taken = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);
  assign jmp_tgt   = a[PC_WIDTH-1:0];
  assign pc_inc    = pc + 1'b1;
  assign self_jmp  = jmp_taken && (jmp_tgt == pc);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  if (instr_ack) nxt = S_DECODE;
      S_DECODE: begin
        if (!ir[15])     nxt = S_FETCH;
        else if (ir[12]) nxt = S_MREAD;
        else             nxt = S_EXEC;
      end
      S_MREAD:  if (mem_ack) nxt = S_EXEC;
      S_EXEC: begin
`ifdef HACK_HALT_SELFJUMP_EN
        if (self_jmp)   nxt = S_HALT;
        else if (ir[3]) nxt = S_MWRITE;
        else            nxt = S_FETCH;
`else
        nxt = ir[3] ? S_MWRITE : S_FETCH;
`endif
      end
      S_MWRITE: if (mem_ack) nxt = S_FETCH;
`ifdef HACK_HALT_SELFJUMP_EN
      S_HALT:   nxt = S_HALT;
`endif
      default:  nxt = S_RST;
    endcase
  end

  // Bus outputs decoded from the registered state only.
  always_comb begin
    instr_req = (state == S_FETCH);
    mem_req   = (state == S_MREAD) || (state == S_MWRITE);
    mem_we    = (state == S_MWRITE);
    mem_addr  = (state == S_MWRITE) ? waddr : a[PC_WIDTH-1:0];
  end

  assign instr_addr = pc;
  assign mem_wdata  = res;
  assign alu_x      = d;
  assign alu_y      = ir[12] ? m_lat : a;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[11:6];
  assign pc_o       = pc;
  assign a_o        = a;
  assign d_o        = d;

`ifdef HACK_HALT_SELFJUMP_EN
  logic halted_q;
  // Sticky halt flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            halted_q <= 1'b0;
    else if (state == S_EXEC && self_jmp)  halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Architectural registers and transaction latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= PC_WIDTH'(RESET_PC);
      a     <= '0;
      d     <= '0;
      ir    <= '0;
      m_lat <= '0;
      res   <= '0;
      waddr <= '0;
    end else begin
      case (state)
        S_FETCH: if (instr_ack) ir <= instr_rdata;
        S_DECODE: if (!ir[15]) begin
          a  <= {1'b0, ir[14:0]};
          pc <= pc_inc;
        end
        S_MREAD: if (mem_ack) m_lat <= mem_rdata;
        S_EXEC: begin
          res   <= alu_out;
          waddr <= a[PC_WIDTH-1:0];
          if (ir[4]) d <= alu_out;
          if (ir[5]) a <= alu_out;
`ifdef HACK_HALT_SELFJUMP_EN
          if (self_jmp)       pc <= pc;
          else if (jmp_taken) pc <= jmp_tgt;
          else                pc <= pc_inc;
`else
          pc <= jmp_taken ? jmp_tgt : pc_inc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Directed bench for hack_cpu_seq: ROM/RAM/ALU models, hand-timed checks.
module tb_hack_cpu_seq;
  localparam int PW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req, instr_ack;
  logic [PW-1:0] instr_addr, mem_addr, pc_o;
  logic [15:0]   instr_rdata, mem_wdata, mem_rdata, alu_x, alu_y, alu_out, a_o, d_o;
  logic          mem_req, mem_we, mem_ack;
  logic          alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng, halted;

  logic [15:0] rom [256];
  logic [15:0] rd_val = 16'h0;
  int          mdly = 0;
  int          mcnt, n_wr, n_rd, n_mreq;
  logic [PW-1:0] last_waddr;
  logic [15:0]   last_wdata;
  int n_chk = 0, n_fail = 0;

  hack_cpu_seq #(.PC_WIDTH(PW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_rdata(instr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
    .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc_o(pc_o), .a_o(a_o), .d_o(d_o), .halted(halted)
  );

  always #5 clk = ~clk;

  // zero-wait ROM
  assign instr_ack   = instr_req;
  assign instr_rdata = rom[instr_addr[7:0]];

  // RAM: ack after mdly wait cycles; reads return rd_val
  assign mem_ack   = mem_req && (mcnt >= mdly);
  assign mem_rdata = rd_val;

  // Hack ALU model
  logic [15:0] x1, x2, y1, y2, o1;
  always_comb begin
    x1 = alu_zx ? 16'h0 : alu_x;
    x2 = alu_nx ? ~x1 : x1;
    y1 = alu_zy ? 16'h0 : alu_y;
    y2 = alu_ny ? ~y1 : y1;
    o1 = alu_f ? (x2 + y2) : (x2 & y2);
    alu_out = alu_no ? ~o1 : o1;
  end
  assign alu_zr = (alu_out == 16'h0);
  assign alu_ng = alu_out[15];

  // wait counter and transaction monitor
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0; n_wr <= 0; n_rd <= 0; n_mreq <= 0;
      last_waddr <= '0; last_wdata <= '0;
    end else begin
      if (mem_req) n_mreq <= n_mreq + 1;
      if (mem_req && !mem_ack) mcnt <= mcnt + 1;
      else                     mcnt <= 0;
      if (mem_req && mem_ack && mem_we) begin
        n_wr <= n_wr + 1; last_waddr <= mem_addr; last_wdata <= mem_wdata;
      end
      if (mem_req && mem_ack && !mem_we) n_rd <= n_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reset with fresh ROM; on return the DUT is in RST (cycle 0)
  task automatic do_reset(input int dly);
    rst_n = 1'b0;
    mdly  = dly;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // T1: reset state and A-instruction latency
    do_reset(0);
    chk("rst_instr_req", instr_req, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_a", a_o, 0);
    chk("rst_d", d_o, 0);
    chk("rst_halted", halted, 0);
    rom[0] = 16'h0005;
    release_rst();
    step(1);
    chk("t1_first_req", instr_req, 1);
    chk("t1_addr0", instr_addr, 0);
    step(2);
    chk("t1_a", a_o, 5);
    chk("t1_pc", pc_o, 1);

    // T2: @21; D=A
    do_reset(0);
    rom[0] = 16'h0015; rom[1] = 16'hEC10;
    release_rst();
    step(5);
    chk("t2_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 6'b110000);
    chk("t2_alu_y", alu_y, 21);
    step(1);
    chk("t2_d", d_o, 21);
    chk("t2_pc", pc_o, 2);
    chk("t2_no_mreq", n_mreq, 0);

    // T3: @7; D=A; @100; M=D+1
    do_reset(0);
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
    release_rst();
    step(10);
    chk("t3_exec_x", alu_x, 7);
    step(1);
    chk("t3_wr_req", {mem_req, mem_we}, 2'b11);
    chk("t3_wr_addr", mem_addr, 100);
    chk("t3_wr_data", mem_wdata, 8);
    step(1);
    chk("t3_req_low", mem_req, 0);
    chk("t3_fetch", {instr_req, 16'(instr_addr)}, {1'b1, 16'd4});
    chk("t3_nwr", n_wr, 1);
    chk("t3_waddr", last_waddr, 100);
    chk("t3_wdata", last_wdata, 8);

    // T4a: D=-1; @40; D;JGT -> not taken
    do_reset(0);
    rom[0] = 16'hEE90; rom[1] = 16'h0028; rom[2] = 16'hE301;
    release_rst();
    step(8);
    chk("t4a_x", alu_x, 16'hFFFF);
    step(1);
    chk("t4a_pc", pc_o, 3);

    // T4b: @3; D=A; @40; D;JGT -> taken
    do_reset(0);
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'h0028; rom[3] = 16'hE301;
    release_rst();
    step(11);
    chk("t4b_pc", pc_o, 40);
    chk("t4b_fetch", instr_addr, 40);

    // T5: @50; AM=M-1 with M[50]=1 and 3 wait cycles per data transaction
    do_reset(3);
    rd_val = 16'h0001;
    rom[0] = 16'h0032; rom[1] = 16'hFCA8;
    release_rst();
    step(5);
    chk("t5_rd_req", {mem_req, mem_we}, 2'b10);
    chk("t5_rd_addr", mem_addr, 50);
    step(2);
    chk("t5_rd_hold", {mem_req, 16'(mem_addr)}, {1'b1, 16'd50});
    step(2);
    chk("t5_exec_y", alu_y, 1);
    chk("t5_nrd", n_rd, 1);
    step(1);
    chk("t5_wr_req", {mem_req, mem_we}, 2'b11);
    chk("t5_a", a_o, 0);
    step(2);
    chk("t5_wr_hold_addr", mem_addr, 50);
    chk("t5_wr_hold_data", mem_wdata, 0);
    chk("t5_wr_pending", n_wr, 0);
    step(2);
    chk("t5_nwr", n_wr, 1);
    chk("t5_waddr", last_waddr, 50);
    chk("t5_wdata", last_wdata, 0);
    chk("t5_fetch", instr_addr, 2);

    // T6: reset pulse during MWRITE wait
    do_reset(3);
    rd_val = 16'h0001;
    rom[0] = 16'h0032; rom[1] = 16'hFCA8;
    release_rst();
    step(11);
    chk("t6_in_wr", mem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_req", mem_req, 0);
    chk("t6_async_pc", pc_o, 0);
    release_rst();
    step(3);
    chk("t6_no_write", n_wr, 0);
    chk("t6_refetch", instr_addr, 1);

    // T7: @8 at PC7, 0;JMP at PC8 (self-jump)
    do_reset(0);
    rom[7] = 16'h0008; rom[8] = 16'hEA87;
    release_rst();
    step(20);
`ifdef HACK_HALT_SELFJUMP_EN
    chk("t7_halted", halted, 1);
    chk("t7_no_req", instr_req, 0);
    step(3);
    chk("t7_parked", {instr_req, mem_req}, 2'b00);
    chk("t7_pc", pc_o, 8);
`else
    chk("t7_halted", halted, 0);
    chk("t7_refetch", {instr_req, 16'(instr_addr)}, {1'b1, 16'd8});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_cpu_seq.md
Name: hack_cpu_seq

Overview:
- Multi-cycle Hack CPU sequencer: fetches 16-bit Hack instructions over a request/acknowledge instruction port and decodes them.
- Drives the ALU control word (zx,nx,zy,ny,f,no) and ALU operands, consumes the ALU result and zr/ng flags.
- Owns the A, D and PC registers and performs data-memory read/write transactions.
- Sits between instruction ROM, data RAM and the existing ALU; it is the control side of the ALU interface.

Parameters:
- PC_WIDTH, 15, width of PC and of both address buses.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_req  output  1  instruction fetch request.
- instr_addr  output  PC_WIDTH  fetch address (= PC).
- instr_ack  input  1  fetch accepted; instr_rdata valid this cycle.
- instr_rdata  input  16  instruction word.
- mem_req  output  1  data transaction request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  PC_WIDTH  data address.
- mem_wdata  output  16  write data.
- mem_ack  input  1  transaction complete; mem_rdata valid on reads.
- mem_rdata  input  16  read data.
- alu_x  output  16  = D.
- alu_y  output  16  = M latch if IR[12]=1, else A.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  = IR[11:6] in order.
- alu_out  input  16  ALU result.
- alu_zr, alu_ng  input  1 each  ALU flags.
- pc_o, a_o, d_o  output  PC_WIDTH/16/16  debug copies of the PC, A and D registers.
- halted  output  1  see Optional Feature; tied 0 when that feature is compiled out.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=RST, PC=RESET_PC, A=0, D=0, IR=0, M latch=0, halted=0. All req/we outputs are 0 during reset and in RST.
- State outputs: instr_req/mem_req/mem_we are decoded from the registered state. ALU controls are driven from IR at all times but are meaningful only in EXEC.
- RST: go to FETCH next cycle.
- FETCH: instr_req=1, instr_addr=PC.
  - On an edge with instr_ack=1: IR<=instr_rdata, go to DECODE.
  - Otherwise hold; address must stay stable.
- DECODE:
  - IR[15]=0 (A-instruction): A<={0,IR[14:0]}, PC<=PC+1, go to FETCH.
  - IR[15]=1 and IR[12]=1: go to MREAD.
  - Otherwise: go to EXEC.
- MREAD: mem_req=1, mem_we=0, mem_addr=A[PC_WIDTH-1:0]. On mem_ack: M latch<=mem_rdata, go to EXEC.
- EXEC: sample alu_out/zr/ng; result latch<=alu_out.
  - If IR[4]: D<=alu_out.
  - If IR[5]: A<=alu_out.
  - Jump taken = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr). Taken: PC<=old A[PC_WIDTH-1:0]; else PC<=PC+1.
  - Write address latch<=old A.
  - Next state: MWRITE if IR[3], else FETCH.
- MWRITE: mem_req=1, mem_we=1, mem_addr=write address latch (pre-update A), mem_wdata=result latch. On mem_ack go to FETCH.
- Handshake rules:
  - req stays high, and addr/we/wdata stay stable, until ack is sampled high.
  - Same-cycle ack is allowed.
  - req is low in the cycle after the accepting edge.
  - Ack while req=0 is ignored.
- Latency with zero-wait memory:
  - A-instruction: 2 cycles.
  - C-instruction: 3 cycles, +1 if a=1, +1 if M is a destination.
- Width and wrap: PC increment wraps modulo 2^PC_WIDTH. IR[14:13] are ignored on C-instructions.
- Reset mid-operation: reset asserted in any state returns immediately to reset values, abandoning the in-flight transaction; no write is repeated after release.

Optional Feature:
- Macro: HACK_HALT_SELFJUMP_EN.
- When defined: a taken jump in EXEC whose target equals the current PC sets halted=1.
  - PC is held and the block parks in a HALT state with no further requests.
  - Only reset clears halted.
- When undefined: no HALT state; halted tied 0; a self-jump refetches forever.

Test Plan:
- Reset, instr 0x0005 at PC0 with zero-wait ack -> A=5, pc_o=1 two cycles after the first instr_req.
- A=21 then 0xEC10 (D=A) -> ALU ctrl 110000 in EXEC; D=21, no mem_req.
- A=100, D=7, 0xE7C8 (M=D+1) -> exactly one write, addr 100, data 8, then FETCH of the next PC.
- D=-1 and 0xE301 (D;JGT), A=40 -> PC+1; repeat with D=3 -> PC=40.
- A=50, M[50]=1, 0xFCA8 (AM=M-1), mem_ack delayed 3 cycles per transaction -> read at 50, write 0 to 50 with addr/data stable while waiting; A=0 afterwards.
- Reset pulse during MWRITE wait -> mem_req low asynchronously, pc_o=RESET_PC. With HACK_HALT_SELFJUMP_EN: @8 at PC7, 0xEA87 at PC8 -> halted=1 and no further instr_req.
